// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon types: 320-bit state as five 64-bit words, the 5-bit S-box
// table and the FSM encoding used by the iterative substitution layer.
package ascon_aead128_pkg;

    localparam int ASCON_COLS = 64;

    typedef logic [4:0][63:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sbox_layer_fsm_t;

    // Indexed by column value {x0,x1,x2,x3,x4}, x0 in bit 4.
    localparam logic [4:0] S_BOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

endpackage

// File: rtl/sbox.sv
// Single Ascon 5-bit S-box lookup, purely combinational.
module sbox
    import ascon_aead128_pkg::*;
(
    input  logic [4:0] x,
    output logic [4:0] y
);

    assign y = S_BOX[x];

endmodule

// File: rtl/sbox_layer_iter_lanes.sv
// One slice of the substitution layer: gathers LANES columns selected by the
// slice index, runs them through S-boxes and writes them back into a state copy.
module sbox_layer_iter_lanes
    import ascon_aead128_pkg::*;
#(
    parameter int LANES = 8,
    parameter int CW    = 3
) (
    input  logic [4:0][63:0] st_i,
    input  logic [CW-1:0]    cnt_i,
    output logic [4:0][63:0] st_o
);

    logic [4:0] sub [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [5:0] idx;
        logic [4:0] col;

        assign idx = 6'(int'(cnt_i) * LANES + l);
        assign col = {st_i[0][idx], st_i[1][idx], st_i[2][idx], st_i[3][idx], st_i[4][idx]};

        sbox u_sbox (
            .x (col),
            .y (sub[l])
        );
    end

    always_comb begin
        logic [5:0] widx;
        st_o = st_i;
        widx = '0;
        for (int l = 0; l < LANES; l++) begin
            widx = 6'(int'(cnt_i) * LANES + l);
            st_o[0][widx] = sub[l][4];
            st_o[1][widx] = sub[l][3];
            st_o[2][widx] = sub[l][2];
            st_o[3][widx] = sub[l][1];
            st_o[4][widx] = sub[l][0];
        end
    end

endmodule

// File: rtl/sbox_layer_iter.sv
// Iterative Ascon p_S layer: substitutes LANES columns per clock in place,
// taking 64/LANES RUN cycles, with valid/ready handshakes on both sides.
module sbox_layer_iter
    import ascon_aead128_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0][63:0] in_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0][63:0] out_state,
    output logic             busy
);

    localparam int SAFE_LANES = (LANES < 1) ? 1 : LANES;
    localparam int NSLICE     = ASCON_COLS / SAFE_LANES;
    localparam int CW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if (LANES < 1 || (ASCON_COLS % SAFE_LANES) != 0) begin : g_bad_lanes
        $error("sbox_layer_iter: LANES must be >= 1 and divide 64");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid are registered and never depend on the partner.
    sbox_layer_fsm_t fsm_q, fsm_d;
    state_t          st_q, st_d, st_slice;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    sbox_layer_iter_lanes #(
        .LANES (SAFE_LANES),
        .CW    (CW)
    ) u_lanes (
        .st_i  (st_q),
        .cnt_i (cnt_q),
        .st_o  (st_slice)
    );

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        cnt_d = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    st_d  = in_state;
                    cnt_d = '0;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                st_d = st_slice;
                if (cnt_q == LAST) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        in_ready_d  = (fsm_d == IDLE);
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = st_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sbox_layer_iter.sv
// Bench for sbox_layer_iter with three instances (LANES = 8, 1, 64) checked
// against a column-by-column reference of the Ascon substitution layer.
module tb_sbox_layer_iter;

    localparam logic [4:0] TBL [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic clk = 1'b0;
    logic rst;
    logic in_valid_a [3];
    logic in_ready_a [3];
    logic out_valid_a [3];
    logic out_ready_a [3];
    logic busy_a [3];
    logic [4:0][63:0] in_state_a [3];
    logic [4:0][63:0] out_state_a [3];

    logic [319:0] exp_q0[$];
    logic [319:0] exp_q1[$];
    logic [319:0] exp_q2[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_layer_iter #(.LANES(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .in_state(in_state_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .out_state(out_state_a[0]), .busy(busy_a[0])
    );
    sbox_layer_iter #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .in_state(in_state_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .out_state(out_state_a[1]), .busy(busy_a[1])
    );
    sbox_layer_iter #(.LANES(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .in_state(in_state_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .out_state(out_state_a[2]), .busy(busy_a[2])
    );

    // reference model: every column replaced by its S-box image
    function automatic logic [319:0] ref_ps(input logic [319:0] v);
        logic [4:0][63:0] s, r;
        logic [4:0] c, y;
        s = v;
        for (int i = 0; i < 64; i++) begin
            c = {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
            y = TBL[c];
            r[0][i] = y[4]; r[1][i] = y[3]; r[2][i] = y[2]; r[3][i] = y[1]; r[4][i] = y[0];
        end
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int w = 0; w < 10; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic push_exp(input int g, input logic [319:0] e);
        case (g)
            0: exp_q0.push_back(e);
            1: exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int g, output bit ok, output logic [319:0] e);
        ok = 1'b0;
        e  = '0;
        case (g)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // scoreboard monitor: compare at every output handshake
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 3; g++) begin
                if (out_valid_a[g] && out_ready_a[g]) begin
                    bit ok;
                    logic [319:0] e;
                    pop_exp(g, ok, e);
                    if (!ok) begin
                        n_checks++;
                        $display("FAIL spurious_out%0d: output %0h with no expected entry", g, out_state_a[g]);
                    end else begin
                        check($sformatf("out_state%0d", g), out_state_a[g], e);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic send(input int g, input logic [319:0] s);
        int t = 0;
        while (!in_ready_a[g] && t < 300) begin @(posedge clk); #1; t++; end
        if (!in_ready_a[g]) begin
            n_checks++;
            $display("FAIL send_timeout%0d: in_ready stayed 0, expected 1", g);
        end else begin
            in_valid_a[g] = 1'b1;
            in_state_a[g] = s;
            @(posedge clk); #1;
            in_valid_a[g] = 1'b0;
            in_state_a[g] = rand_state();
            push_exp(g, ref_ps(s));
        end
    endtask

    task automatic wait_valid(input int g, input int lat, input string name);
        int n = 0;
        while (!out_valid_a[g] && n < 300) begin @(posedge clk); #1; n++; end
        check(name, 320'(n), 320'(lat));
    endtask

    task automatic release_out(input int g);
        out_ready_a[g] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[g] = 1'b0;
        check($sformatf("busy_after_release%0d", g), 320'(busy_a[g]), 320'(0));
        check($sformatf("in_ready_after_release%0d", g), 320'(in_ready_a[g]), 320'(1));
    endtask

    initial begin
        logic [4:0][63:0] z, o, walk, s, other;
        logic [63:0] base;
        logic [4:0] c_in, c_out;
        int acc [4];
        int t;

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid_a[g] = 1'b0; out_ready_a[g] = 1'b0; in_state_a[g] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_in_ready%0d", g), 320'(in_ready_a[g]), 320'(0));
            check($sformatf("rst_out_valid%0d", g), 320'(out_valid_a[g]), 320'(0));
            check($sformatf("rst_busy%0d", g), 320'(busy_a[g]), 320'(0));
            check($sformatf("rst_out_state%0d", g), out_state_a[g], '0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", 320'(in_ready_a[0]), 320'(1));

        // all-zero state: x2 becomes all ones
        z = '0; z[2] = '1;
        send(0, '0);
        wait_valid(0, 8, "lat_zero_l8");
        check("zero_l8", out_state_a[0], z);
        release_out(0);

        // all-ones state on every lane count
        o = '1; o[1] = '0;
        send(0, '1);
        wait_valid(0, 8, "lat_ones_l8");
        check("ones_l8", out_state_a[0], o);
        release_out(0);
        send(1, '1);
        wait_valid(1, 64, "lat_ones_l1");
        check("ones_l1", out_state_a[1], o);
        release_out(1);
        send(2, '1);
        wait_valid(2, 1, "lat_ones_l64");
        check("ones_l64", out_state_a[2], o);
        release_out(2);

        // column walk, every column against the table
        base = 64'h0123_4567_89AB_CDEF;
        for (int w = 0; w < 5; w++) walk[w] = (base << (13 * w)) | (base >> (64 - 13 * w));
        walk[0] = base;
        send(0, walk);
        wait_valid(0, 8, "lat_walk");
        for (int i = 0; i < 64; i++) begin
            c_in  = {walk[0][i], walk[1][i], walk[2][i], walk[3][i], walk[4][i]};
            c_out = {out_state_a[0][0][i], out_state_a[0][1][i], out_state_a[0][2][i],
                     out_state_a[0][3][i], out_state_a[0][4][i]};
            check($sformatf("walk_col%0d", i), 320'(c_out), 320'(TBL[c_in]));
        end
        release_out(0);

        // random states on the other lane counts
        for (int g = 1; g < 3; g++) begin
            send(g, rand_state());
            wait_valid(g, (g == 1) ? 64 : 1, $sformatf("lat_rand%0d", g));
            release_out(g);
        end

        // backpressure in DONE
        s = rand_state();
        send(0, s);
        wait_valid(0, 8, "lat_bp");
        other = rand_state();
        in_valid_a[0] = 1'b1;
        in_state_a[0] = other;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 320'(out_valid_a[0]), 320'(1));
            check("bp_out_state", out_state_a[0], ref_ps(s));
            check("bp_in_ready", 320'(in_ready_a[0]), 320'(0));
        end
        out_ready_a[0] = 1'b1;
        in_valid_a[0] = 1'b0;
        @(posedge clk); #1;
        out_ready_a[0] = 1'b0;
        check("bp_in_ready_after", 320'(in_ready_a[0]), 320'(1));
        check("bp_out_valid_after", 320'(out_valid_a[0]), 320'(0));
        repeat (12) @(posedge clk);
        #1;
        check("bp_ignored_input", 320'(busy_a[0]), 320'(0));

        // reset in the middle of RUN at cnt=3
        send(0, rand_state());
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q0.pop_back());
        check("midrst_out_valid", 320'(out_valid_a[0]), 320'(0));
        check("midrst_busy", 320'(busy_a[0]), 320'(0));
        check("midrst_out_state", out_state_a[0], '0);
        check("midrst_in_ready", 320'(in_ready_a[0]), 320'(0));
        send(0, rand_state());
        wait_valid(0, 8, "lat_after_rst");
        release_out(0);

        // back-to-back with out_ready and in_valid held high
        out_ready_a[0] = 1'b1;
        in_valid_a[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            s = rand_state();
            in_state_a[0] = s;
            t = 0;
            while (!in_ready_a[0] && t < 300) begin @(posedge clk); #1; t++; end
            @(posedge clk); #1;
            push_exp(0, ref_ps(s));
            acc[j] = cyc;
        end
        in_valid_a[0] = 1'b0;
        for (int j = 1; j < 4; j++)
            check($sformatf("b2b_interval%0d", j), 320'(acc[j] - acc[j-1]), 320'(10));
        t = 0;
        while (exp_q0.size() > 0 && t < 100) begin @(posedge clk); #1; t++; end
        out_ready_a[0] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("drain_q0", 320'(exp_q0.size()), 320'(0));
        check("drain_q1", 320'(exp_q1.size()), 320'(0));
        check("drain_q2", 320'(exp_q2.size()), 320'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
